// File: rtl/acc_rd_arbiter.sv
// -----------------------------------------------------------------------------
// acc_rd_arbiter
//   Round-robin arbiter and burst sequencer for the single-port operand SRAM
//   read port of the multiply-add accelerator. Grants one burst at a time. It
//   issues consecutive incrementing read addresses, which wrap modulo
//   2^ADDR_W. The SRAM read data is steered back to the owning requester
//   RD_LAT cycles later, tagged with valid and last.
//
// Ports
//   clk, rst_n    : clock (rising edge), asynchronous active-low reset
//   req_valid_i   : per-requester burst request
//   req_addr_i    : packed start addresses, slice k belongs to requester k
//   req_len_i     : packed burst lengths (beats-1), slice k per requester
//   req_ready_o   : one-hot single-cycle acceptance pulse (IDLE only)
//   mem_en_o      : registered SRAM read enable
//   mem_addr_o    : registered SRAM read address
//   mem_rdata_i   : SRAM read data, valid RD_LAT cycles after mem_en_o
//   rsp_valid_o   : one-hot response valid
//   rsp_data_o    : response data (pass-through of mem_rdata_i)
//   rsp_last_o    : final beat of a burst
//   busy_o        : burst active or responses still in flight
//   grant_id_o    : id of the current or last granted requester
// -----------------------------------------------------------------------------
module acc_rd_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 6,
  parameter int RD_LAT  = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic                      mem_en_o,
  output logic [ADDR_W-1:0]         mem_addr_o,
  input  logic [DATA_W-1:0]         mem_rdata_i,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  output logic [DATA_W-1:0]         rsp_data_o,
  output logic                      rsp_last_o,
  output logic                      busy_o,
  output logic [2:0]                grant_id_o
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  localparam logic [3:0] NREQ4   = 4'(NUM_REQ);
  localparam logic [2:0] LAST_ID = 3'(NUM_REQ - 1);

  logic [0:0]        r_state;
  logic [2:0]        r_rr_ptr;
  logic [2:0]        r_id;
  logic              r_mem_en;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_beat;

  // Response pipeline: index 0 is loaded from the issue stage, RD_LAT-1 is the tail
  logic [RD_LAT-1:0] r_pipe_vld;
  logic [RD_LAT-1:0] r_pipe_last;
  logic [2:0]        r_pipe_id [RD_LAT];

  logic [7:0]        w_vld8;
  logic [ADDR_W-1:0] w_addr_arr [8];
  logic [LEN_W-1:0]  w_len_arr  [8];
  logic [3:0]        w_idx;
  logic              w_found;
  logic [2:0]        w_winner;
  logic [2:0]        w_ptr_nxt;
  logic              w_in_burst;
  logic              w_issue_last;

  // Requester slices are padded to 8 entries so a 3-bit id can index them
  // for any NUM_REQ in 2..8.
  assign w_vld8 = 8'(req_valid_i);

  for (genvar k = 0; k < 8; k++) begin : g_slice
    if (k < NUM_REQ) begin : g_real
      assign w_addr_arr[k] = req_addr_i[k*ADDR_W +: ADDR_W];
      assign w_len_arr[k]  = req_len_i[k*LEN_W +: LEN_W];
    end else begin : g_pad
      assign w_addr_arr[k] = '0;
      assign w_len_arr[k]  = '0;
    end
  end

  // Round-robin scan starting at r_rr_ptr; first valid requester wins.
  always_comb begin
    w_found  = 1'b0;
    w_winner = 3'd0;
    w_idx    = 4'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = {1'b0, r_rr_ptr} + 4'(i);
      if (w_idx >= NREQ4) w_idx = w_idx - NREQ4;
      if (!w_found && w_vld8[w_idx[2:0]]) begin
        w_found  = 1'b1;
        w_winner = w_idx[2:0];
      end
    end
  end

  assign w_ptr_nxt    = (w_winner == LAST_ID) ? 3'd0 : w_winner + 3'd1;
  assign w_in_burst   = (r_state == S_BURST);
  assign w_issue_last = w_in_burst && (r_beat == r_len);

  // Control state: FSM, pointer, issue port and pipeline valid bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= 3'd0;
      r_id       <= 3'd0;
      r_mem_en   <= 1'b0;
      r_mem_addr <= '0;
      r_pipe_vld <= '0;
    end else begin
      if (r_state == S_IDLE) begin
        if (w_found) begin
          r_state    <= S_BURST;
          r_rr_ptr   <= w_ptr_nxt;
          r_id       <= w_winner;
          r_mem_en   <= 1'b1;
          r_mem_addr <= w_addr_arr[w_winner];
        end
      end else begin
        if (w_issue_last) begin
          r_state  <= S_IDLE;
          r_mem_en <= 1'b0;
        end else begin
          r_mem_addr <= r_mem_addr + 1'b1;
        end
      end
      r_pipe_vld[0] <= w_in_burst;
      for (int k = 1; k < RD_LAT; k++) r_pipe_vld[k] <= r_pipe_vld[k-1];
    end
  end

  // Datapath state: burst length, beat counter, pipeline id/last tags.
  // These are only meaningful when qualified by the control state above.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE) begin
      if (w_found) begin
        r_len  <= w_len_arr[w_winner];
        r_beat <= '0;
      end
    end else if (!w_issue_last) begin
      r_beat <= r_beat + 1'b1;
    end
    r_pipe_id[0]   <= r_id;
    r_pipe_last[0] <= w_issue_last;
    for (int k = 1; k < RD_LAT; k++) begin
      r_pipe_id[k]   <= r_pipe_id[k-1];
      r_pipe_last[k] <= r_pipe_last[k-1];
    end
  end

  // Acceptance is suppressed while reset is held so no pulse is seen then.
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_onehot
    assign req_ready_o[k] = rst_n && (r_state == S_IDLE) && w_found && (w_winner == 3'(k));
    assign rsp_valid_o[k] = r_pipe_vld[RD_LAT-1] && (r_pipe_id[RD_LAT-1] == 3'(k));
  end

  assign mem_en_o   = r_mem_en;
  assign mem_addr_o = r_mem_addr;
  assign rsp_data_o = mem_rdata_i;
  assign rsp_last_o = r_pipe_vld[RD_LAT-1] && r_pipe_last[RD_LAT-1];
  assign busy_o     = w_in_burst || (|r_pipe_vld);
  assign grant_id_o = r_id;

endmodule

// File: doc/acc_rd_arbiter.md
Name: acc_rd_arbiter

Overview:
- Round-robin arbiter and burst sequencer for the single-port operand SRAM read port in the multiply-add accelerator.
- Serves NUM_REQ requesters: h_bus loader, v_bus loader and formatted-result reader.
- Accepts one burst request at a time and issues consecutive incrementing read addresses.
- Routes the read data back to the owning requester after a fixed SRAM read latency, with valid and last tags.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
ADDR_W, 10, SRAM address width; addresses wrap modulo 2^ADDR_W
DATA_W, 32, SRAM read data width
LEN_W, 6, burst length field width; length field = beats-1 (1..64 beats)
RD_LAT, 2, SRAM read latency in cycles from mem_en_o to valid mem_rdata_i (>=1)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid_i  input  NUM_REQ  per-requester burst request
req_addr_i  input  NUM_REQ*ADDR_W  start address; slice k belongs to requester k
req_len_i  input  NUM_REQ*LEN_W  beats-1; slice k belongs to requester k
req_ready_o  output  NUM_REQ  one-hot, single-cycle acceptance pulse
mem_en_o  output  1  SRAM read enable
mem_addr_o  output  ADDR_W  SRAM read address
mem_rdata_i  input  DATA_W  SRAM read data, valid RD_LAT cycles after mem_en_o
rsp_valid_o  output  NUM_REQ  one-hot response valid
rsp_data_o  output  DATA_W  response data, combinational pass-through of mem_rdata_i
rsp_last_o  output  1  marks the final beat of a burst, qualified by any rsp_valid_o
busy_o  output  1  high while a burst is active or responses are in flight
grant_id_o  output  3  id of the current or last granted requester

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE; rr_ptr = 0.
  - req_ready_o, mem_en_o, rsp_valid_o, rsp_last_o, busy_o = 0.
  - mem_addr_o = 0; grant_id_o = 0.
  - Response pipeline is cleared; in-flight beats are dropped and never reported.
- FSM states: IDLE, BURST.
- IDLE:
  - If any req_valid_i is high, select the winner by scanning ids rr_ptr, rr_ptr+1, … modulo NUM_REQ; the first one with valid set wins.
  - Assert req_ready_o[winner] combinationally in this cycle.
  - Latch the winner's addr/len and the winner id; set rr_ptr = (winner+1) mod NUM_REQ.
  - Go to BURST.
  - If no request is valid, stay in IDLE with no outputs asserted.
- Handshake:
  - A request transfers when req_valid_i[k] and req_ready_o[k] are both high.
  - The requester holds addr/len stable while valid is high.
  - Dropping valid before acceptance is legal; it is simply not considered next cycle.
  - req_ready_o is never asserted in BURST.
- BURST:
  - mem_en_o = 1 every cycle.
  - mem_addr_o = start + beat, truncated to ADDR_W (wraps 2^ADDR_W-1 -> 0).
  - beat counts 0..len.
  - When beat == len, return to IDLE on the next edge. This leaves one mandatory idle cycle (the arbitration cycle) between bursts.
  - mem_en_o and mem_addr_o are registered outputs.
- Latency:
  - Request accepted in cycle T; first mem_en_o in T+1.
  - Beat i is issued in T+1+i.
  - rsp_valid_o[id] for beat i is asserted in T+1+i+RD_LAT.
- Response pipeline:
  - RD_LAT-deep shift register of {valid, id, last}, loaded from the issue stage every cycle.
  - rsp_last_o = 1 on the beat issued with beat == len.
  - Output is the pipeline tail.
  - Responses of consecutive bursts can overlap with issue of the next burst; ids keep them separated.
- busy_o = (state == BURST) OR any pipeline stage valid.
- Fairness: a requester that keeps valid asserted is served within NUM_REQ-1 other bursts.
- len=0: single beat, with rsp_last_o on that beat.
- No backpressure on responses; requesters must always accept rsp_valid_o.

Test Plan:
- Single burst with wrap: req 0, addr=0x3FE, len=3.
  - Addresses 0x3FE, 0x3FF, 0x000, 0x001 are issued in T+1..T+4.
  - rsp_valid_o=3'b001 in T+3..T+6, with rsp_last_o only at T+6.
  - busy_o falls at T+7.
- Full contention: all three req_valid held high, len=1 each.
  - Grant order is 0, 1, 2, 0.
  - Each req_ready_o is one cycle wide, with exactly one IDLE cycle between bursts.
- Pointer fairness: after a grant to 0, requesters 0 and 2 are valid → 2 is granted before 0. After that, 0 and 1 are valid → 0 is granted.
- len=0 back-to-back from requester 1: two single-beat bursts.
  - mem_en_o pattern is 0,1,0,1 from the first IDLE cycle.
  - Each response has rsp_last_o=1 and rsp_data_o equal to the SRAM model data.
- Async reset mid-burst: rst_n asserted low at beat 2 of len=7, asynchronously between clock edges.
  - mem_en_o, rsp_valid_o and busy_o drop immediately.
  - After release, no stale responses appear and requester 0 wins first.
- Withdrawn request: req 2 raises valid for one cycle while a burst is active, then drops it.
  - It is never granted.
  - No req_ready_o[2] pulse occurs.
